// File: rtl/iob_rr_arbiter.sv
// Registered N-way arbiter with optional round-robin masking and grant hold.
// One encoder resolves raw requests and a second resolves mask-filtered requests.
// The winner is registered as a one-hot grant plus an encoded index.
module iob_rr_arbiter #(
  parameter int unsigned PORTS        = 4,
  parameter int unsigned ROUND_ROBIN  = 1,
  parameter string       BLOCK        = "NONE",
  parameter string       LSB_PRIORITY = "LOW"
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [PORTS-1:0]         request_i,
  input  logic [PORTS-1:0]         acknowledge_i,
  output logic [PORTS-1:0]         grant_o,
  output logic                     grant_valid_o,
  output logic [$clog2(PORTS)-1:0] grant_encoded_o
);

  localparam int unsigned IdxW     = $clog2(PORTS);
  localparam bit          UseRr    = (ROUND_ROBIN != 0);
  localparam bit          BlockReq = (BLOCK == "REQUEST");
  localparam bit          BlockAck = (BLOCK == "ACKNOWLEDGE");
  // Any other BLOCK string falls through to never-hold behaviour.
  localparam bit          HighPri  = (LSB_PRIORITY == "HIGH");

  logic [PORTS-1:0] grant_q, grant_d;
  logic             valid_q, valid_d;
  logic [IdxW-1:0]  enc_q, enc_d;
  logic [PORTS-1:0] mask_q, mask_d;

  logic             hold;
  logic [PORTS-1:0] masked;
  logic [IdxW-1:0]  win_raw, win_masked, win;

  // "LOW": highest set index wins; "HIGH": lowest set index wins.
  function automatic logic [IdxW-1:0] encode(input logic [PORTS-1:0] vec);
    logic [IdxW-1:0] idx;
    idx = '0;
    if (HighPri) begin
      for (int i = int'(PORTS) - 1; i >= 0; i--) begin
        if (vec[i]) idx = IdxW'(i);
      end
    end else begin
      for (int i = 0; i < int'(PORTS); i++) begin
        if (vec[i]) idx = IdxW'(i);
      end
    end
    return idx;
  endfunction

  // Ports still eligible after winner w: those on the losing side of the priority order.
  function automatic logic [PORTS-1:0] next_mask(input logic [IdxW-1:0] w);
    logic [PORTS-1:0] m;
    m = '0;
    for (int i = 0; i < int'(PORTS); i++) begin
      if (HighPri) m[i] = (i > int'(w));
      else         m[i] = (i < int'(w));
    end
    return m;
  endfunction

  assign masked     = request_i & mask_q;
  assign win_raw    = encode(request_i);
  assign win_masked = encode(masked);
  assign win        = (UseRr && (masked != '0)) ? win_masked : win_raw;

  // Hold decision and next grant/mask state.
  always_comb begin
    hold    = 1'b0;
    grant_d = grant_q;
    valid_d = valid_q;
    enc_d   = enc_q;
    mask_d  = mask_q;

    if (BlockReq) begin
      hold = valid_q && request_i[enc_q];
    end else if (BlockAck) begin
      hold = valid_q && !acknowledge_i[enc_q];
    end

    if (!hold) begin
      if (request_i != '0) begin
        grant_d      = '0;
        grant_d[win] = 1'b1;
        valid_d      = 1'b1;
        enc_d        = win;
        if (UseRr) mask_d = next_mask(win);
      end else begin
        // Idle: drop the grant but keep round-robin history.
        grant_d = '0;
        valid_d = 1'b0;
        enc_d   = '0;
      end
    end
  end

  // Grant and mask registers, synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      grant_q <= '0;
      valid_q <= 1'b0;
      enc_q   <= '0;
      mask_q  <= '0;
    end else begin
      grant_q <= grant_d;
      valid_q <= valid_d;
      enc_q   <= enc_d;
      mask_q  <= mask_d;
    end
  end

  assign grant_o         = grant_q;
  assign grant_valid_o   = valid_q;
  assign grant_encoded_o = enc_q;

endmodule
